// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: redirect input, imem request/response channel and decode handshake
interface instr_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential word fetch into an in-order queue with redirect flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int DW = 8;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     pc_q [QDEPTH];
    logic [31:0]     pc_d [QDEPTH];
    logic [31:0]     data_q [QDEPTH];
    logic [31:0]     data_d [QDEPTH];
    logic [QDEPTH-1:0] filled_q, filled_d;
    logic [AW-1:0]   head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
    logic [CW-1:0]   alloc_cnt_q, alloc_cnt_d, n_filled;
    logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            req_valid, acc, pop;

    assign req_valid          = !rst && !bus.redirect_valid && (alloc_cnt_q < CW'(QDEPTH));
    assign acc                = req_valid && bus.imem_req_ready;
    assign pop                = filled_q[head_q] && bus.inst_ready;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = filled_q[head_q];
    assign bus.inst_data      = data_q[head_q];
    assign bus.inst_pc        = pc_q[head_q];

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pc_d        = pc_q;
        data_d      = data_q;
        filled_d    = filled_q;
        head_d      = head_q;
        alloc_d     = alloc_q;
        fill_d      = fill_q;
        alloc_cnt_d = alloc_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        n_filled    = '0;
        for (int i = 0; i < QDEPTH; i++) n_filled = n_filled + CW'(filled_q[i]);
        if (bus.redirect_valid) begin
            filled_d    = '0;
            head_d      = '0;
            alloc_d     = '0;
            fill_d      = '0;
            alloc_cnt_d = '0;
            fetch_pc_d  = {bus.redirect_pc[31:2], 2'b00};
            // every request still owed a response is dropped, minus the one arriving now
            drop_cnt_d  = drop_cnt_q + DW'(alloc_cnt_q - n_filled) - DW'(bus.imem_rsp_valid);
        end else begin
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + AW'(1);
            end
            if (acc) begin
                pc_d[alloc_q]     = fetch_pc_q;
                filled_d[alloc_q] = 1'b0;
                alloc_d           = alloc_q + AW'(1);
                fetch_pc_d        = fetch_pc_q + 32'd4;
            end
            if (bus.imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - DW'(1);
                end else begin
                    data_d[fill_q]   = bus.imem_rsp_data;
                    filled_d[fill_q] = 1'b1;
                    fill_d           = fill_q + AW'(1);
                end
            end
            alloc_cnt_d = alloc_cnt_q + CW'(acc) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            pc_q        <= '{default: '0};
            data_q      <= '{default: '0};
            filled_q    <= '0;
            head_q      <= '0;
            alloc_q     <= '0;
            fill_q      <= '0;
            alloc_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pc_q        <= pc_d;
            data_q      <= data_d;
            filled_q    <= filled_d;
            head_q      <= head_d;
            alloc_q     <= alloc_d;
            fill_q      <= fill_d;
            alloc_cnt_q <= alloc_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized memory/decode/redirect stimulus checked each cycle
// against a queue-based model of the fetch stream, plus directed literal checks.
module tb_instr_fetch_unit;
    localparam int          QDEPTH = 4;
    localparam logic [31:0] MAGIC  = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();
    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_pct, irdy_pct, redir_pct, lat_min, lat_max;
    bit redir_force = 0;
    logic [31:0] redir_tgt;

    mreq_t       mem_q[$];
    int          last_due;
    logic [31:0] m_pc;
    int          m_alloc, m_filled, m_stale;
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] del_log[$];
    int          first_acc, first_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        last_due = 0;
        m_pc = 32'h0000_0000;
        m_alloc = 0;
        m_filled = 0;
        m_stale = 0;
        exp_q.delete();
        acc_log.delete();
        del_log.delete();
        first_acc = -1;
        first_val = -1;
    endtask

    task automatic check_zero_outputs();
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst_data", bus.inst_data, 0);
        check("rst_inst_pc", bus.inst_pc, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.inst_ready = 1'b0;
        #1;
        check_zero_outputs();
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_zero_outputs();
        end
    endtask

    task automatic check_and_update();
        bit e_rv, e_acc, e_pop, dut_acc, dut_pop;
        int lat, due;
        e_rv = !bus.redirect_valid && (m_alloc < QDEPTH);
        check("req_valid", bus.imem_req_valid, e_rv);
        if (e_rv) check("req_addr", bus.imem_req_addr, m_pc);
        check("inst_valid", bus.inst_valid, m_filled > 0);
        if (m_filled > 0 && exp_q.size() > 0) begin
            check("inst_pc", bus.inst_pc, exp_q[0]);
            check("inst_data", bus.inst_data, exp_q[0] ^ MAGIC);
        end
        dut_acc = bus.imem_req_valid && bus.imem_req_ready;
        dut_pop = bus.inst_valid && bus.inst_ready;
        if (dut_acc) begin
            acc_log.push_back(bus.imem_req_addr);
            if (first_acc < 0) first_acc = cyc;
        end
        if (dut_pop) del_log.push_back(bus.inst_pc);
        if (bus.inst_valid && first_val < 0) first_val = cyc;
        if (bus.imem_rsp_valid) begin
            assert (mem_q.size() > 0) else $error("response with no request in flight");
            if (mem_q.size() > 0) mem_q.pop_front();
        end
        e_acc = e_rv && bus.imem_req_ready;
        e_pop = (m_filled > 0) && bus.inst_ready;
        if (bus.redirect_valid) begin
            // whatever memory still owes us is stale
            m_stale = mem_q.size();
            m_alloc = 0;
            m_filled = 0;
            exp_q.delete();
            m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (e_acc) begin
                exp_q.push_back(m_pc);
                m_alloc++;
                m_pc = m_pc + 32'd4;
            end
            if (bus.imem_rsp_valid) begin
                if (m_stale > 0) m_stale--;
                else m_filled++;
            end
            if (e_pop) begin
                m_alloc--;
                m_filled--;
                if (exp_q.size() > 0) exp_q.pop_front();
            end
        end
        if (dut_acc) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: bus.imem_req_addr, due: due});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = mem_q[0].addr ^ MAGIC;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data = $urandom;
        end
        bus.inst_ready = ($urandom_range(99) < irdy_pct);
        if (redir_force) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = redir_tgt;
            redir_force = 0;
        end else begin
            bus.redirect_valid = ($urandom_range(99) < redir_pct);
            bus.redirect_pc = $urandom;
        end
        @(negedge clk);
        check_and_update();
    endtask

    task automatic knobs(input int rp, input int ip, input int dp, input int lmin, input int lmax);
        rdy_pct = rp;
        irdy_pct = ip;
        redir_pct = dp;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        knobs(100, 100, 0, 1, 1);
        do_reset();

        // steady stream at 1-cycle latency
        repeat (12) cycle();
        check("first_valid_latency", first_val - first_acc, 2);
        check("stream_deliveries", del_log.size(), 10);
        check("stream_pc0", del_log[0], 32'h0);
        check("stream_pc1", del_log[1], 32'h4);
        check("stream_pc7", del_log[7], 32'h1C);

        // decode stalled: queue fills, requests stop
        do_reset();
        knobs(100, 0, 0, 1, 1);
        repeat (20) cycle();
        check("bp_accepts", acc_log.size(), 4);
        check("bp_addr3", acc_log[3], 32'hC);
        check("bp_req_valid_low", bus.imem_req_valid, 0);
        knobs(100, 100, 0, 1, 1);
        repeat (10) cycle();
        check("bp_del0", del_log[0], 32'h0);
        check("bp_del3", del_log[3], 32'hC);

        // redirect with 3 requests in flight at 4-cycle latency
        do_reset();
        knobs(100, 100, 0, 4, 4);
        repeat (3) cycle();
        redir_tgt = 32'h0000_1003;
        redir_force = 1;
        repeat (11) cycle();
        check("redir_next_addr", acc_log[3], 32'h1000);
        check("redir_first_pc", del_log[0], 32'h1000);

        // redirect in the same cycle as a response and a pop
        do_reset();
        knobs(100, 100, 0, 1, 1);
        repeat (6) cycle();
        redir_tgt = 32'h0000_2000;
        redir_force = 1;
        repeat (7) cycle();
        check("same_cyc_count", del_log.size(), 9);
        check("same_cyc_popped", del_log[4], 32'h10);
        check("same_cyc_after", del_log[5], 32'h2000);

        // fetch address wraps past the top of memory
        do_reset();
        repeat (2) cycle();
        redir_tgt = 32'hFFFF_FFF8;
        redir_force = 1;
        repeat (5) cycle();
        check("wrap_a0", acc_log[2], 32'hFFFF_FFF8);
        check("wrap_a1", acc_log[3], 32'hFFFF_FFFC);
        check("wrap_a2", acc_log[4], 32'h0000_0000);

        // reset with two filled entries and two requests in flight
        do_reset();
        knobs(100, 0, 0, 3, 3);
        repeat (5) cycle();
        check("pre_rst_valid", bus.inst_valid, 1);
        do_reset();
        knobs(100, 100, 0, 1, 1);
        repeat (4) cycle();
        check("post_rst_addr", acc_log[0], 32'h0);
        check("post_rst_pc", del_log[0], 32'h0);

        // randomized traffic
        for (int k = 0; k < 4; k++) begin
            do_reset();
            knobs(100 - k * 15, 100 - k * 20, (k == 0) ? 0 : 2 + k, 1, 1 + k * 2);
            repeat (600) cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the MIPS core. It owns the fetch address and issues sequential word reads to instruction memory over a valid/ready request channel, accepting in-order responses with variable latency. Fetched words go into a QDEPTH-entry instruction queue, and each word is handed to decode together with its PC. A redirect from execute (branch or jump) flushes the queue, discards in-flight responses and restarts fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset.
- QDEPTH, 4: instruction queue entries, power of 2, ≥2; also the maximum number of outstanding requests.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored and treated as 0.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned read address (= fetch_pc).
- imem_rsp_valid  in  1  read data valid; one response per accepted request, in order, earliest the cycle after acceptance.
- imem_rsp_data  in  32  read data.
- inst_valid  out  1  queue head holds a fetched instruction.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  address of the head instruction.

## Operation
- State:
  - fetch_pc.
  - Circular queue of QDEPTH entries {pc, data, filled}, with head, alloc and fill pointers.
  - alloc_cnt (0..QDEPTH): entries allocated and not popped.
  - drop_cnt (0..QDEPTH): responses still to discard.
- Request:
  - imem_req_valid = !rst && !redirect_valid && alloc_cnt < QDEPTH.
  - imem_req_addr = fetch_pc.
  - On acceptance (valid && ready): allocate the entry at the alloc pointer with pc = fetch_pc and filled = 0; fetch_pc += 4 (mod 2^32, wraps to 0).
  - A request may be withdrawn only by redirect.
- Response:
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise: write data to the entry at the fill pointer, set filled = 1, advance the fill pointer.
- Output:
  - inst_valid = filled bit of the head entry.
  - inst_data and inst_pc come from the head entry.
  - On inst_valid && inst_ready: pop the head and decrement alloc_cnt.
- Simultaneous allocate and pop: alloc_cnt unchanged.
- Allocation is gated on the registered alloc_cnt, so there is no same-cycle bypass when the queue is full.
- Redirect (priority over everything else):
  - A decode handshake in the same cycle still completes.
  - All queue entries are cleared (filled = 0, alloc_cnt = 0, pointers reset to equal).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - drop_cnt <= drop_cnt + (in-flight non-dropped requests) − (1 if a non-dropped response arrives this cycle). That response is discarded.
  - No request is issued in the redirect cycle.
- A response with no in-flight request is a protocol violation; behaviour is undefined and flagged by a bench assertion.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, alloc_cnt = 0, drop_cnt = 0, all filled = 0.
  - inst_valid = 0, inst_data = 0, inst_pc = 0, imem_req_valid = 0 while rst is high.
- First request: imem_req_valid = 1 with addr RESET_PC in the first cycle after rst deasserts.
- Minimum latency: request accepted in cycle N, response in N+1, inst_valid in N+2.
- Full throughput: one instruction per cycle when memory responds every cycle and decode is always ready.
- Redirect in cycle N: the request in N+1 carries the target; inst_valid = 0 from N+1 until the target's response has been filled.
- rst asserted mid-operation: immediate return to reset values. Responses from before the reset are not tracked; the memory model must also reset.
- Back-pressure: with inst_ready = 0, at most QDEPTH requests are issued, then imem_req_valid drops.

## Test plan
- Reset release, memory returns word = addr ^ 32'hA5A5_A5A5 with 1-cycle latency, decode always ready → inst_pc sequence 0, 4, 8, …; inst_valid first high 2 cycles after the first accept; one instruction per cycle.
- inst_ready = 0 for 20 cycles (QDEPTH = 4) → exactly 4 requests accepted (addrs 0, 4, 8, C), imem_req_valid = 0 afterwards; releasing ready delivers 0, 4, 8, C in order with correct data.
- Redirect to 32'h0000_1003 with 3 requests in flight at 4-cycle latency → next request addr 32'h0000_1000; the 3 stale responses are discarded; next inst_pc = 32'h1000.
- Redirect in the same cycle as a response and a decode pop → the popped instruction is delivered once, the response is dropped, drop_cnt is correct, and there are no duplicate or missing PCs after the redirect.
- Fetch from redirect target 32'hFFFF_FFF8 → addrs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap-around).
- Assert rst while the queue holds 2 entries and 2 requests are in flight → all outputs return to reset values immediately; after release, fetch resumes at RESET_PC.
